// File: rtl/crc_pkg.sv
// crc_pkg: shared FSM state type and default CRC-8 generator for the CRC stream block.
package crc_pkg;
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    localparam logic [7:0] CRC8_DIVISOR = 8'b0000_0111;
endpackage

// File: rtl/crc_step.sv
// crc_step: folds a DW-bit beat (MSB first) into a CRC_BW-bit remainder in one combinational pass.
module crc_step
    import crc_pkg::*;
#(
    parameter int DW = 8,
    parameter int CRC_BW = 8,
    parameter logic [CRC_BW-1:0] DIVISOR = CRC_BW'(CRC8_DIVISOR)
)(
    input  logic [CRC_BW-1:0] crc,
    input  logic [DW-1:0]     data,
    output logic [CRC_BW-1:0] nxt
);
    logic [CRC_BW-1:0] c;
    logic [DW-1:0]     d;
    always_comb begin
        c = crc;
        d = data;
        for (int i = 0; i < DW; i++) begin
            c = {c[CRC_BW-2:0], 1'b0} ^ ((c[CRC_BW-1] ^ d[DW-1]) ? DIVISOR : '0);
            d = d << 1;
        end
        nxt = c;
    end
endmodule

// File: rtl/crc_stream.sv
// crc_stream: framed CRC generator/checker with a one-entry result handshake.
// Optional saturating error counter output err_cnt enabled by macro CRC_STREAM_ERR_CNT_EN.
module crc_stream
    import crc_pkg::*;
#(
    parameter int DW = 8,
    parameter int CRC_BW = 8,
    parameter logic [CRC_BW-1:0] DIVISOR = CRC_BW'(CRC8_DIVISOR)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic              in_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CRC_BW-1:0] res_crc,
    output logic              res_err
`ifdef CRC_STREAM_ERR_CNT_EN
    ,
    output logic [15:0]       err_cnt
`endif
);
    state_t            state, state_nxt;
    logic [CRC_BW-1:0] crc, crc_nxt;
    logic              mode_q, acc;
    assign acc = in_valid && in_ready;
    // a frame's first beat folds into zero, so no separate clear cycle is needed
    crc_step #(.DW(DW), .CRC_BW(CRC_BW), .DIVISOR(DIVISOR)) u_step (
        .crc  (state == IDLE ? '0 : crc),
        .data (in_data),
        .nxt  (crc_nxt)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (state == DONE) state_nxt = res_ready ? IDLE : DONE;
        else if (acc)      state_nxt = in_last ? DONE : ACC;
    end
    always_comb begin
        in_ready  = state != DONE;
        res_valid = state == DONE;
        res_crc   = res_valid ? crc : '0;
        res_err   = res_valid && mode_q && (crc != '0);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc    <= '0;
            mode_q <= 1'b0;
        end else if (acc) begin
            crc    <= crc_nxt;
            mode_q <= state == IDLE ? mode : mode_q;
        end
    end
`ifdef CRC_STREAM_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt <= '0;
        else if (res_valid && res_ready && res_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_crc_stream.sv
// tb_crc_stream: table-driven frames with a result scoreboard, plus hold, reset-abort and random-frame sequences.
module tb_crc_stream;
    typedef struct packed {
        logic             m;
        logic [4:0]       n;
        logic [15:0][7:0] d;
        logic [7:0]       crc;
        logic             err;
        logic             gaps;
    } vec_t;
    typedef struct packed {
        logic [7:0] crc;
        logic       err;
    } res_t;

    logic       clk = 0, rst = 1, mode = 0, in_valid = 0, in_last = 0, res_ready = 0;
    logic [7:0] in_data = 0;
    logic       in_ready, res_valid, res_err;
    logic [7:0] res_crc;
    int         checks = 0, errors = 0;
    res_t       q[$];
`ifdef CRC_STREAM_ERR_CNT_EN
    logic [15:0] err_cnt;
    int          exp_cnt = 0;
`endif

    crc_stream dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .res_valid(res_valid), .res_ready(res_ready),
        .res_crc(res_crc), .res_err(res_err)
`ifdef CRC_STREAM_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // augmented long division: shift message then CRC_BW zeros through the register
    function automatic logic [7:0] model(input logic [15:0][7:0] d, input int n);
        logic [7:0] r = 0;
        logic       top;
        for (int i = 0; i < n + 1; i++)
            for (int b = 7; b >= 0; b--) begin
                top = r[7];
                r = {r[6:0], i < n ? d[i][b] : 1'b0};
                if (top) r = r ^ 8'h07;
            end
        return r;
    endfunction

    function automatic vec_t mk(input logic m, input int n, input logic gaps, input logic [7:0] crc, input logic err);
        vec_t v = '0;
        v.m = m; v.n = 5'(n); v.gaps = gaps; v.crc = crc; v.err = err;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic m);
        int   w = 0;
        logic ok;
        in_valid = 1; in_data = d; in_last = last; mode = m;
        do begin
            ok = in_ready;
            cyc();
            w++;
        end while (!ok && w < 20);
        if (!ok) chk("beat_accept_timeout", 0, 1);
        in_valid = 0; in_data = 8'($urandom); in_last = 1'($urandom);
    endtask

    task automatic collect();
        int   w = 0;
        res_t e;
        while (!res_valid && w < 10) begin
            cyc();
            w++;
        end
        chk("latency", w, 0);
        if (res_valid && q.size() > 0) begin
            e = q.pop_front();
            chk("res_crc", res_crc, e.crc);
            chk("res_err", res_err, e.err);
            res_ready = 1;
            cyc();
            res_ready = 0;
            chk("in_ready_after_hs", in_ready, 1);
            chk("res_valid_after_hs", res_valid, 0);
`ifdef CRC_STREAM_ERR_CNT_EN
            if (e.err) exp_cnt++;
            chk("err_cnt", err_cnt, exp_cnt);
`endif
        end else chk("result_available", 0, 1);
    endtask

    task automatic drive_frame(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            if (v.gaps)
                repeat ($urandom_range(0, 2)) begin
                    in_data = 8'($urandom); in_last = 1'($urandom);
                    cyc();
                end
            send_beat(v.d[i], i == v.n - 1, i == 0 ? v.m : ~v.m);
        end
    endtask

    task automatic run_frame(input vec_t v);
        q.push_back('{crc: v.crc, err: v.err});
        drive_frame(v);
        collect();
    endtask

    initial begin
        vec_t tv[8];
        vec_t v;
        tv[0] = mk(0, 1, 0, 8'h07, 0); tv[0].d[0] = 8'h01;
        tv[1] = mk(0, 9, 0, 8'hF4, 0);
        for (int i = 0; i < 9; i++) tv[1].d[i] = 8'h31 + 8'(i);
        tv[2] = mk(1, 2, 0, 8'h00, 0); tv[2].d[0] = 8'h01; tv[2].d[1] = 8'h07;
        tv[3] = mk(1, 2, 0, 8'h07, 1); tv[3].d[0] = 8'h01; tv[3].d[1] = 8'h06;
        tv[4] = mk(0, 1, 0, 8'h00, 0);
        tv[5] = tv[1]; tv[5].m = 1; tv[5].n = 10; tv[5].d[9] = 8'hF4; tv[5].crc = 8'h00;
        tv[6] = tv[1]; tv[6].gaps = 1;
        tv[7] = tv[5]; tv[7].d[3] = 8'h00; tv[7].err = 1; tv[7].crc = model(tv[7].d, 10);

        #3;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_crc", res_crc, 0);
        chk("rst_res_err", res_err, 0);
`ifdef CRC_STREAM_ERR_CNT_EN
        chk("rst_err_cnt", err_cnt, 0);
`endif
        cyc();
        rst = 0;
        cyc();
        chk("in_ready_after_rst", in_ready, 1);

        for (int i = 0; i < 8; i++) run_frame(tv[i]);

        // result held while res_ready is low; offered beats must not be taken
        v = mk(0, 1, 0, 8'h00, 0); v.d[0] = 8'hAB; v.crc = model(v.d, 1);
        q.push_back('{crc: v.crc, err: 1'b0});
        send_beat(8'hAB, 1, 0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_res_valid", res_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_res_crc", res_crc, v.crc);
            in_valid = 1; in_data = 8'h55; in_last = 1;
            cyc();
        end
        collect();
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_no_extra_result", res_valid, 0);
        end

        // abort "123456789" after two beats in check mode, then rerun it cleanly
        send_beat(8'h31, 0, 1);
        send_beat(8'h32, 0, 1);
        rst = 1;
        #2;
        chk("abort_res_valid", res_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        cyc();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("abort_no_result", res_valid, 0);
        end
        run_frame(tv[1]);

        for (int k = 0; k < 4; k++) begin
            v = mk(k[0], $urandom_range(1, 6), 1, 8'h00, 0);
            for (int i = 0; i < 15; i++) v.d[i] = 8'($urandom);
            if (k[0]) begin
                v.d[v.n] = model(v.d, v.n);
                v.n = v.n + 5'd1;
            end else v.crc = model(v.d, v.n);
            run_frame(v);
        end

        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/crc_stream.md
CRC_STREAM -- requirements
Module: crc_stream

Interface
REQ-001 SHALL have parameter DW, default 8: data bits accepted per beat (1..64).
REQ-002 SHALL have parameter CRC_BW, default 8: CRC width in bits (2..32).
REQ-003 SHALL have parameter DIVISOR, default 8'b0000_0111: generator polynomial without its implicit leading 1, CRC_BW bits wide.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port mode, input, 1: 0 = generate, 1 = check; sampled on the first accepted beat of a frame.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, DW) and in_last (input, 1): beat stream, MSB of in_data processed first.
REQ-008 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_crc (output, CRC_BW) and res_err (output, 1): per-frame result.

Function
REQ-009 SHALL implement an FSM with states IDLE, ACC and DONE.
REQ-010 SHALL accept a beat on any cycle where in_valid and in_ready are both 1; in_ready SHALL be 1 in IDLE and ACC, and 0 in DONE.
REQ-011 SHALL, per accepted beat and per bit b (MSB first), update: fb = crc[MSB]^b; crc = (crc<<1) ^ (fb ? DIVISOR : 0); the full DW bits are consumed in one cycle.
REQ-012 SHALL load the register with 0 at frame start; the first beat is applied to the value 0 in the same cycle it is accepted.
REQ-013 SHALL move IDLE->ACC on an accepted beat with in_last=0, IDLE->DONE on an accepted beat with in_last=1 (single-beat frame), and ACC->DONE on an accepted beat with in_last=1.
REQ-014 SHALL assert res_valid in DONE, i.e. the cycle after the last beat is accepted (latency 1), holding res_crc/res_err stable until res_ready=1.
REQ-015 SHALL, in generate mode, drive res_crc = remainder of payload*x^CRC_BW and res_err = 0.
REQ-016 SHALL, in check mode (frame = payload followed by CRC, padded to whole beats by the sender), drive res_crc = final remainder and res_err = (remainder != 0).
REQ-017 SHALL move DONE->IDLE when res_ready=1, with in_ready=1 on the following cycle; no beat is accepted in the handshake cycle.
REQ-018 SHALL ignore mode changes after the first beat of a frame.
REQ-019 SHALL ignore in_data and in_last while in_valid=0, and SHALL keep the CRC unchanged across idle gaps inside a frame.

Reset
REQ-020 SHALL, on rst=1, immediately force state IDLE, crc=0, res_valid=0, res_err=0, res_crc=0 and the latched mode to 0, with in_ready=1 after release.
REQ-021 SHALL discard a frame in progress at reset with no result produced.

Configuration
REQ-022 SHALL provide macro CRC_STREAM_ERR_CNT_EN: when defined, adds output err_cnt (16 bits, reset 0), which increments on each DONE->IDLE handshake with res_err=1 and saturates at 16'hFFFF; when undefined, the port and counter are absent and all other behaviour is identical.

Structure
REQ-023 SHALL take the FSM state typedef and the default CRC-8 divisor constant from shared package crc_pkg.
REQ-024 SHALL contain one combinational sub-module, crc_step (parameters DW, CRC_BW, DIVISOR; in: crc, data; out: next crc), which implements REQ-011.

Verification
REQ-025 SHALL cover: DW=8, generate mode, single beat 0x01 with in_last=1 -> res_valid the next cycle, res_crc=0x07, res_err=0.
REQ-026 SHALL cover: DW=8, generate mode, ASCII "123456789" as 9 beats -> res_crc=0xF4.
REQ-027 SHALL cover: check mode, beats 0x01,0x07 -> res_err=0, res_crc=0x00; beats 0x01,0x06 -> res_err=1, and err_cnt increments by 1 when CRC_STREAM_ERR_CNT_EN is defined.
REQ-028 SHALL cover: res_ready held 0 for 5 cycles in DONE -> res_valid and res_crc stable, in_ready=0, and offered beats not consumed.
REQ-029 SHALL cover: rst pulsed after beat 2 of "123456789", then a fresh full frame -> no result for the aborted frame, and the fresh frame gives 0xF4.
REQ-030 SHALL cover: in_valid toggled randomly within a generate-mode "123456789" frame -> res_crc=0xF4.
